// File: rtl/fx2_ep_sched_if.sv
// ---------------------------------------------------------------------------
// fx2_ep_sched_if
// Bundles the FX2 endpoint flags, the local resource status, the datapath
// byte handshake and the scheduler's grant outputs into one port.
//   slave  : the scheduler (samples flags/status/strobes, drives grant side)
//   master : the datapath / environment (drives flags/status/strobes)
// Signals:
//   usb_ep2_empty, usb_ep4_empty : FX2 OUT FIFOs empty (EP2, EP4 read side)
//   usb_ep6_full,  usb_ep8_full  : FX2 IN FIFOs full  (EP6, EP8 write side)
//   ep2_ready, ep4_ready         : local sinks can accept bytes
//   ep6_avail, ep8_avail         : local sources hold bytes
//   xfer_strobe, xfer_last       : one byte moved / packet end
//   usb_addr[1:0]                : FX2 FIFOADDR
//   grant[3:0], grant_valid      : one-hot grant and its qualifier
//   grant_read                   : granted endpoint is FX2->FPGA
//   burst_count[9:0]             : bytes moved in the current grant
// ---------------------------------------------------------------------------
interface fx2_ep_sched_if;
   logic       usb_ep2_empty;
   logic       usb_ep4_empty;
   logic       usb_ep6_full;
   logic       usb_ep8_full;
   logic       ep2_ready;
   logic       ep4_ready;
   logic       ep6_avail;
   logic       ep8_avail;
   logic       xfer_strobe;
   logic       xfer_last;
   logic [1:0] usb_addr;
   logic [3:0] grant;
   logic       grant_valid;
   logic       grant_read;
   logic [9:0] burst_count;

   modport slave (
      input  usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full,
      input  ep2_ready, ep4_ready, ep6_avail, ep8_avail,
      input  xfer_strobe, xfer_last,
      output usb_addr, grant, grant_valid, grant_read, burst_count
   );

   modport master (
      output usb_ep2_empty, usb_ep4_empty, usb_ep6_full, usb_ep8_full,
      output ep2_ready, ep4_ready, ep6_avail, ep8_avail,
      output xfer_strobe, xfer_last,
      input  usb_addr, grant, grant_valid, grant_read, burst_count
   );
endinterface

// File: rtl/fx2_ep_scheduler.sv
// ---------------------------------------------------------------------------
// fx2_ep_scheduler
// Chooses which FX2 endpoint owns the shared FX2 data bus. EP2/EP4 are read
// from the FX2, EP6/EP8 are written to it. An endpoint is eligible when its
// FX2 flag allows a transfer and the local resource behind it is ready.
// The block drives FIFOADDR, inserts bus turnaround idle cycles when the
// address changes, and caps every grant at BURST_MAX bytes.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : fx2_ep_sched_if.slave (flags, status, strobes in; grant out)
//
// Parameters:
//   BURST_MAX  : max bytes per grant (1..1023)
//   TURNAROUND : idle cycles after usb_addr changes (0..7)
//
// Build option:
//   FX2_EP_PRIORITY_EN : EP4 then EP8 get strict priority; EP2/EP6 share
//                        round robin only when both are ineligible.
//                        Undefined -> plain 4-way round robin.
// ---------------------------------------------------------------------------
module fx2_ep_scheduler #(
   parameter int unsigned BURST_MAX  = 512,
   parameter int unsigned TURNAROUND = 2
) (
   input  logic          clk,
   input  logic          reset,
   fx2_ep_sched_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_TURN,
      S_ACTIVE,
      S_RELEASE
   } state_t;

   localparam logic [9:0] BURST_CAP  = 10'(BURST_MAX);
   localparam logic [9:0] BURST_LAST = 10'(BURST_MAX - 1);
   localparam logic [2:0] TURN_LAST  = (TURNAROUND == 0) ? 3'd0 : 3'(TURNAROUND - 1);
   localparam bit         NO_TURN    = (TURNAROUND == 0);

   state_t     state_q, state_d;
   logic [3:0] elig_q;
   logic [1:0] ptr_q, ptr_d;
   logic [1:0] usb_addr_q, usb_addr_d;
   logic       grant_read_q, grant_read_d;
   logic [9:0] burst_q, burst_d;
   logic [2:0] turn_q, turn_d;
   logic [2:0] pick;         // {found, endpoint index}
   logic       acc_strobe;
   logic       burst_end;

   // First set bit of el strictly after ptr, wrapping EP8 -> EP2; the
   // pointer position itself is checked last. Iterating from the farthest
   // offset down lets the nearest eligible endpoint win.
   function automatic logic [2:0] rr_pick(input logic [3:0] el, input logic [1:0] ptr);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int i = 4; i >= 1; i--) begin
         idx = ptr + 2'(i);
         if (el[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         elig_q <= 4'b0000;
      end else begin
         elig_q <= {~bus.usb_ep8_full  & bus.ep8_avail,
                    ~bus.usb_ep6_full  & bus.ep6_avail,
                    ~bus.usb_ep4_empty & bus.ep4_ready,
                    ~bus.usb_ep2_empty & bus.ep2_ready};
      end
   end

   always_comb begin
`ifdef FX2_EP_PRIORITY_EN
      if (elig_q[1])      pick = {1'b1, 2'd1};
      else if (elig_q[3]) pick = {1'b1, 2'd3};
      else                pick = rr_pick(elig_q & 4'b0101, ptr_q);
`else
      pick = rr_pick(elig_q, ptr_q);
`endif
   end

   // Strobes only count while the grant is presented.
   assign acc_strobe = bus.xfer_strobe & (state_q == S_ACTIVE);
   assign burst_end  = acc_strobe & (bus.xfer_last | (burst_q >= BURST_LAST));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         ptr_q        <= 2'd3;
         usb_addr_q   <= 2'd0;
         grant_read_q <= 1'b0;
         burst_q      <= 10'd0;
         turn_q       <= 3'd0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         usb_addr_q   <= usb_addr_d;
         grant_read_q <= grant_read_d;
         burst_q      <= burst_d;
         turn_q       <= turn_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      usb_addr_d   = usb_addr_q;
      grant_read_d = grant_read_q;
      burst_d      = burst_q;
      turn_d       = turn_q;

      case (state_q)
         S_IDLE: begin
            if (|elig_q) state_d = S_SELECT;
         end

         S_SELECT: begin
            if (!pick[2]) begin
               state_d = S_IDLE;
            end else begin
               usb_addr_d   = pick[1:0];
               grant_read_d = ~pick[1];
               turn_d       = 3'd0;
`ifdef FX2_EP_PRIORITY_EN
               // Only the EP2/EP6 pair rotates; priority picks leave it alone.
               if (!pick[0]) ptr_d = pick[1:0];
`else
               ptr_d = pick[1:0];
`endif
               // Same FIFOADDR as the previous grant needs no turnaround.
               if (pick[1:0] == usb_addr_q || NO_TURN) state_d = S_ACTIVE;
               else                                      state_d = S_TURN;
            end
         end

         S_TURN: begin
            if (turn_q == TURN_LAST) begin
               state_d = elig_q[usb_addr_q] ? S_ACTIVE : S_RELEASE;
            end else begin
               turn_d = turn_q + 3'd1;
            end
         end

         S_ACTIVE: begin
            if (acc_strobe && burst_q != BURST_CAP) burst_d = burst_q + 10'd1;
            // A strobe in the cycle eligibility drops is still counted above.
            if (burst_end || !elig_q[usb_addr_q]) state_d = S_RELEASE;
         end

         S_RELEASE: begin
            burst_d = 10'd0;
            state_d = S_SELECT;
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.usb_addr    = usb_addr_q;
   assign bus.grant_read  = grant_read_q;
   assign bus.grant_valid = (state_q == S_ACTIVE);
   assign bus.grant       = (state_q == S_ACTIVE) ? (4'b0001 << usb_addr_q) : 4'b0000;
   assign bus.burst_count = burst_q;

endmodule
